// File: rtl/e203_irq_stim_gen.sv
// Interrupt stimulus generator for the SoC simulation bench.
// Each of NUM_CH channels arms on a commit-PC match, waits a fixed or
// LFSR-random delay, raises its IRQ, and releases it when the handler's
// acknowledge PC commits (or when the ack timeout expires).
// DLY_W must not exceed 16 (the delay is drawn from the 16-bit LFSR).
module e203_irq_stim_gen #(
  parameter int unsigned NUM_CH  = 3,
  parameter int unsigned PC_SIZE = 32,
  parameter int unsigned DLY_W   = 10,
  parameter int unsigned TMO_W   = 12,
  parameter int unsigned CNT_W   = 16,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cmt_valid,
  input  logic [PC_SIZE-1:0]        cmt_pc,
  input  logic [PC_SIZE-1:0]        arm_pc,
  input  logic [NUM_CH*PC_SIZE-1:0] ack_pc,
  input  logic [NUM_CH-1:0]         ch_en,
  input  logic [NUM_CH-1:0]         rand_mode,
  input  logic [NUM_CH*DLY_W-1:0]   fix_dly,
  input  logic                      stop_i,
  output logic [NUM_CH-1:0]         irq_o,
  output logic [NUM_CH*CNT_W-1:0]   fire_cnt,
  output logic [NUM_CH-1:0]         tmo_err,
  output logic                      armed_o,
  output logic                      drained_o
);

  // Delay counter is one bit wider than DLY_W so that 2^DLY_W fits.
  localparam int unsigned CW = DLY_W + 1;

  typedef enum logic [1:0] {
    CH_IDLE,
    CH_WAIT,
    CH_ASSERT,
    CH_STOP
  } ch_state_e;

  logic              armed_q;
  logic [NUM_CH-1:0] quiet;

  // Arm latch: set by the first commit of the arm PC, held until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q <= 1'b0;
    end else if (cmt_valid && (cmt_pc == arm_pc)) begin
      armed_q <= 1'b1;
    end
  end

  assign armed_o = armed_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    localparam logic [15:0] SEED_MIX = SEED ^ 16'(g * 16'h1357);
    localparam logic [15:0] CH_SEED  = (SEED_MIX == 16'h0000) ? 16'h0001 : SEED_MIX;

    ch_state_e          st_q, st_d;
    logic [CW-1:0]      dly_q, dly_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic               irq_q;
    logic               load;
    logic               ack_hit;
    logic [PC_SIZE-1:0] ack_pc_i;
    logic [DLY_W-1:0]   fix_i;
    logic [15:0]        lfsr_step;
    logic [CW-1:0]      load_val;

    assign ack_pc_i  = ack_pc[g*PC_SIZE +: PC_SIZE];
    assign fix_i     = fix_dly[g*DLY_W +: DLY_W];
    assign ack_hit   = cmt_valid && (cmt_pc == ack_pc_i);
    assign lfsr_step = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    assign load_val  = rand_mode[g] ? ({1'b0, lfsr_q[DLY_W-1:0]} + CW'(1))
                                    : ((fix_i == '0) ? CW'(1) : {1'b0, fix_i});

    // Channel next-state: delay countdown, assert, ack/timeout release, stop.
    always_comb begin
      st_d   = st_q;
      dly_d  = dly_q;
      tmo_d  = tmo_q;
      lfsr_d = lfsr_q;
      cnt_d  = cnt_q;
      err_d  = err_q;
      load   = 1'b0;
      unique case (st_q)
        CH_IDLE: begin
          if (armed_q) begin
            if (stop_i) begin
              st_d = CH_STOP;
            end else if (ch_en[g]) begin
              st_d = CH_WAIT;
              load = 1'b1;
            end
          end
        end
        CH_WAIT: begin
          if (stop_i || !ch_en[g]) begin
            st_d = CH_STOP;
          end else if (dly_q == CW'(1)) begin
            st_d  = CH_ASSERT;
            // Starting at 1 makes the all-ones match land on the
            // (2^TMO_W-1)th cycle of assertion.
            tmo_d = TMO_W'(1);
          end else begin
            dly_d = dly_q - CW'(1);
          end
        end
        CH_ASSERT: begin
          if (ack_hit || (tmo_q == '1)) begin
            if (ack_hit) begin
              if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
            end else begin
              err_d = 1'b1;
            end
            if (stop_i) begin
              st_d = CH_STOP;
            end else begin
              st_d = CH_WAIT;
              load = 1'b1;
            end
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end
        default: begin
          st_d = CH_STOP;
        end
      endcase
      if (load) begin
        dly_d = load_val;
        if (rand_mode[g]) lfsr_d = lfsr_step;
      end
    end

    // Channel state registers; irq is registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st_q   <= CH_IDLE;
        dly_q  <= '0;
        tmo_q  <= '0;
        lfsr_q <= CH_SEED;
        cnt_q  <= '0;
        err_q  <= 1'b0;
        irq_q  <= 1'b0;
      end else begin
        st_q   <= st_d;
        dly_q  <= dly_d;
        tmo_q  <= tmo_d;
        lfsr_q <= lfsr_d;
        cnt_q  <= cnt_d;
        err_q  <= err_d;
        irq_q  <= (st_d == CH_ASSERT);
      end
    end

    assign irq_o[g]                    = irq_q;
    assign tmo_err[g]                  = err_q;
    assign fire_cnt[g*CNT_W +: CNT_W]  = cnt_q;
    assign quiet[g] = !ch_en[g] || (st_q == CH_IDLE) || (st_q == CH_STOP);
  end

  assign drained_o = (&quiet) && !(|irq_o);

endmodule

// File: tb/tb_e203_irq_stim_gen.sv
// Directed bench for e203_irq_stim_gen: fixed/random delays, ack release,
// timeout, stop/drain, shared ack PC and asynchronous reset.
module tb_e203_irq_stim_gen;

  localparam logic [31:0] ARM_PC = 32'h8000_015C;
  localparam logic [31:0] ACK0   = 32'h8000_0200;
  localparam logic [31:0] ACK1   = 32'h8000_0300;
  localparam logic [31:0] ACK2   = 32'h8000_0400;

  logic        clk;
  logic        rst_n;
  logic        cmt_valid;
  logic [31:0] cmt_pc;
  logic [31:0] arm_pc;
  logic [95:0] ack_pc;
  logic [2:0]  ch_en;
  logic [2:0]  rand_mode;
  logic [29:0] fix_dly;
  logic        stop_i;
  logic [2:0]  irq_o;
  logic [47:0] fire_cnt;
  logic [2:0]  tmo_err;
  logic        armed_o;
  logic        drained_o;
  logic [2:0]  irq_s;
  logic [47:0] fire_s;
  logic [2:0]  tmo_s;
  logic        armed_s;
  logic        drained_s;

  int checks = 0;
  int errors = 0;

  e203_irq_stim_gen #(.NUM_CH(3), .PC_SIZE(32), .DLY_W(10), .TMO_W(12), .CNT_W(16),
                      .SEED(16'hACE1)) u_dut (
    .clk(clk), .rst_n(rst_n), .cmt_valid(cmt_valid), .cmt_pc(cmt_pc),
    .arm_pc(arm_pc), .ack_pc(ack_pc), .ch_en(ch_en), .rand_mode(rand_mode),
    .fix_dly(fix_dly), .stop_i(stop_i), .irq_o(irq_o), .fire_cnt(fire_cnt),
    .tmo_err(tmo_err), .armed_o(armed_o), .drained_o(drained_o)
  );

  // Second instance with a different seed, same stimulus.
  e203_irq_stim_gen #(.NUM_CH(3), .PC_SIZE(32), .DLY_W(10), .TMO_W(12), .CNT_W(16),
                      .SEED(16'h1234)) u_seed (
    .clk(clk), .rst_n(rst_n), .cmt_valid(cmt_valid), .cmt_pc(cmt_pc),
    .arm_pc(arm_pc), .ack_pc(ack_pc), .ch_en(ch_en), .rand_mode(rand_mode),
    .fix_dly(fix_dly), .stop_i(stop_i), .irq_o(irq_s), .fire_cnt(fire_s),
    .tmo_err(tmo_s), .armed_o(armed_s), .drained_o(drained_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] lfsr_adv(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [63:0] dly_of(input logic [15:0] v);
    return 64'(v[9:0]) + 64'd1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    cmt_valid = 1'b0;
    cmt_pc    = '0;
    stop_i    = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic do_commit(input logic [31:0] pc);
    cmt_valid = 1'b1;
    cmt_pc    = pc;
    tick();
    cmt_valid = 1'b0;
    cmt_pc    = '0;
  endtask

  // Counts edges until the selected irq is seen high, bounded by maxc.
  task automatic wait_rise(input int sel, input int ch, input int maxc, output int n);
    n = 0;
    while (n < maxc && !((sel == 0) ? irq_o[ch] : irq_s[ch])) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int          n;
    int          h;
    int          pend[3];
    int          rises[$];
    int          exp_rise[10];
    logic [2:0]  prev;
    logic [2:0]  seen;
    logic [15:0] m;

    arm_pc    = ARM_PC;
    ack_pc    = {ACK2, ACK1, ACK0};
    ch_en     = 3'b000;
    rand_mode = 3'b000;
    fix_dly   = {10'd20, 10'd10, 10'd5};
    stop_i    = 1'b0;
    cmt_valid = 1'b0;
    cmt_pc    = '0;
    rst_n     = 1'b0;
    tick();
    tick();
    chk("rst_irq", 64'(irq_o), 64'd0);
    chk("rst_fire", 64'(fire_cnt), 64'd0);
    chk("rst_tmo", 64'(tmo_err), 64'd0);
    chk("rst_armed", 64'(armed_o), 64'd0);
    chk("rst_drained", 64'(drained_o), 64'd1);
    rst_n = 1'b1;

    // Fixed delays 5/10/20, ack 3 cycles after each rise; a stray ack of
    // ch2's PC while ch2 waits must be ignored. Entries are cycle*10+ch,
    // cycle counted from the arm edge (WAIT entry is cycle 1).
    ch_en = 3'b111;
    tick();
    chk("pre_arm_armed", 64'(armed_o), 64'd0);
    do_commit(ARM_PC);
    chk("arm_armed", 64'(armed_o), 64'd1);
    chk("arm_irq", 64'(irq_o), 64'd0);
    exp_rise = '{60, 111, 140, 212, 220, 241, 300, 371, 380, 442};
    prev = '0;
    pend = '{-1, -1, -1};
    for (int k = 1; k <= 45; k++) begin
      tick();
      cmt_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
        if (irq_o[c] && !prev[c]) begin
          rises.push_back(k * 10 + c);
          pend[c] = k + 3;
        end
      end
      prev = irq_o;
      if (k == 4) begin
        cmt_valid = 1'b1;
        cmt_pc    = ACK2;
      end
      for (int c = 0; c < 3; c++) begin
        if (pend[c] == k + 1) begin
          cmt_valid = 1'b1;
          cmt_pc    = ack_pc[c*32 +: 32];
        end
      end
    end
    cmt_valid = 1'b0;
    chk("fix_rise_count", 64'(rises.size()), 64'd10);
    for (int i = 0; i < 10; i++) begin
      chk("fix_rise", 64'((i < rises.size()) ? rises[i] : -1), 64'(exp_rise[i]));
    end
    chk("fix_fire_cnt", 64'(fire_cnt), {16'd0, 16'd1, 16'd3, 16'd5});
    chk("fix_tmo", 64'(tmo_err), 64'd0);
    chk("fix_drained", 64'(drained_o), 64'd0);

    // fix_dly of 0 behaves as 1.
    do_reset();
    fix_dly = {10'd20, 10'd10, 10'd0};
    ch_en   = 3'b001;
    do_commit(ARM_PC);
    tick();
    chk("zero_dly_wait", 64'(irq_o), 64'd0);
    wait_rise(0, 0, 10, n);
    chk("zero_dly_rise", 64'(n), 64'd1);

    // Random mode on ch1, never acked: timeout after 4095 cycles.
    do_reset();
    ch_en     = 3'b010;
    rand_mode = 3'b010;
    do_commit(ARM_PC);
    tick();
    m = 16'hACE1 ^ 16'h1357;
    wait_rise(0, 1, 2000, n);
    chk("rand_first_dly", 64'(n), dly_of(m));
    h = 0;
    while (irq_o[1] && h < 5000) begin
      tick();
      h++;
    end
    chk("tmo_high_len", 64'(h), 64'd4095);
    chk("tmo_err", 64'(tmo_err), 64'b010);
    chk("tmo_fire", 64'(fire_cnt), 64'd0);
    m = lfsr_adv(m);
    wait_rise(0, 1, 2000, n);
    chk("tmo_rewait_dly", 64'(n), dly_of(m));

    // Two identical runs of 20 random IRQs on ch0, acked immediately.
    for (int r = 0; r < 2; r++) begin
      do_reset();
      ch_en     = 3'b001;
      rand_mode = 3'b001;
      do_commit(ARM_PC);
      tick();
      m = 16'hACE1;
      for (int i = 0; i < 20; i++) begin
        wait_rise(0, 0, 1100, n);
        chk("rand_seq_dly", 64'(n), dly_of(m));
        m = lfsr_adv(m);
        do_commit(ACK0);
      end
    end

    // A different seed gives a different first delay.
    do_reset();
    do_commit(ARM_PC);
    tick();
    wait_rise(1, 0, 1100, n);
    chk("seed_first_dly", 64'(n), dly_of(16'h1234));

    // Stop with ch0 waiting and ch1 asserted; STOP stays terminal.
    do_reset();
    rand_mode = 3'b000;
    fix_dly   = {10'd20, 10'd3, 10'd50};
    ch_en     = 3'b011;
    do_commit(ARM_PC);
    tick();
    wait_rise(0, 1, 10, n);
    chk("stop_ch1_rise", 64'(n), 64'd3);
    stop_i = 1'b1;
    tick();
    chk("stop_no_abort", 64'(irq_o), 64'b010);
    chk("stop_not_drained", 64'(drained_o), 64'd0);
    tick();
    tick();
    do_commit(ACK1);
    chk("stop_ack_irq", 64'(irq_o), 64'd0);
    chk("stop_drained", 64'(drained_o), 64'd1);
    chk("stop_fire", 64'(fire_cnt), {16'd0, 16'd0, 16'd1, 16'd0});
    stop_i = 1'b0;
    seen   = '0;
    for (int k = 0; k < 80; k++) begin
      tick();
      seen = seen | irq_o;
    end
    chk("stop_terminal", 64'(seen), 64'd0);
    chk("stop_drained_hold", 64'(drained_o), 64'd1);

    // Shared ack PC releases all channels; async reset mid-assert.
    do_reset();
    fix_dly = {10'd2, 10'd2, 10'd2};
    ch_en   = 3'b111;
    ack_pc  = {ACK0, ACK0, ACK0};
    do_commit(ARM_PC);
    tick();
    wait_rise(0, 0, 10, n);
    chk("shared_rise", 64'(n), 64'd2);
    chk("shared_irq_all", 64'(irq_o), 64'b111);
    do_commit(ACK0);
    chk("shared_release", 64'(irq_o), 64'd0);
    chk("shared_fire", 64'(fire_cnt), {16'd0, 16'd1, 16'd1, 16'd1});
    tick();
    tick();
    chk("shared_rerise", 64'(irq_o), 64'b111);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_irq", 64'(irq_o), 64'd0);
    chk("async_fire", 64'(fire_cnt), 64'd0);
    chk("async_armed", 64'(armed_o), 64'd0);
    chk("async_drained", 64'(drained_o), 64'd1);
    tick();
    rst_n = 1'b1;
    do_commit(ARM_PC);
    tick();
    wait_rise(0, 0, 10, n);
    chk("rearm_rise", 64'(n), 64'd2);
    chk("rearm_irq", 64'(irq_o), 64'b111);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
